// File: rtl/multicyc_mcu.sv
// Multi-cycle MIPS-style control unit: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jump steps, with optional stalling on mem_ready.
module multicyc_mcu #(
  parameter int MEMWAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic       is_beq,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       wreg_dst_sel,
  output logic       wrbck_sel,
  output logic [3:0] aluop,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_debug
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC     = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t state, next_state;
  logic   ready;

  // With waiting disabled the memory is assumed to always complete in one cycle.
  assign ready = (MEMWAIT_EN != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = FETCH;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    is_beq       = 1'b0;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_we       = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 2'b00;
    pc_src       = 2'b00;
    reg_we       = 1'b0;
    wreg_dst_sel = 1'b0;
    wrbck_sel    = 1'b0;
    aluop        = ALU_ADD;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    state_debug  = state;

    case (state)
      FETCH: begin
        mem_rd     = 1'b1;
        alu_b_sel  = 2'b01;
        ir_we      = ready;
        pc_we      = ready;
        next_state = ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_b_sel = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_a_sel  = 1'b1;
        alu_b_sel  = 2'b10;
        next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord       = 1'b1;
        mem_rd     = 1'b1;
        next_state = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_we     = 1'b1;
        wrbck_sel  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mem_we     = ready;
        instr_done = ready;
        next_state = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_a_sel  = 1'b1;
        aluop      = ALU_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_we       = 1'b1;
        wreg_dst_sel = 1'b1;
        instr_done   = 1'b1;
      end
      BRANCH: begin
        alu_a_sel  = 1'b1;
        aluop      = ALU_SUB;
        is_beq     = 1'b1;
        pc_src     = 2'b01;
        instr_done = 1'b1;
      end
      ADDIEXEC: begin
        alu_a_sel  = 1'b1;
        alu_b_sel  = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_we      = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      default: begin
        next_state = FETCH;
      end
    endcase

    // Reset silences every output so an aborted access never writes anything.
    if (reset) begin
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      is_beq       = 1'b0;
      iord         = 1'b0;
      mem_rd       = 1'b0;
      mem_we       = 1'b0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 2'b00;
      pc_src       = 2'b00;
      reg_we       = 1'b0;
      wreg_dst_sel = 1'b0;
      wrbck_sel    = 1'b0;
      aluop        = ALU_ADD;
      instr_done   = 1'b0;
      illegal_op   = 1'b0;
      state_debug  = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicyc_mcu.sv
// Directed bench for multicyc_mcu: walks each instruction class cycle by
// cycle and compares state and control outputs with hand-derived values.
module tb_multicyc_mcu;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ir_we, pc_we, is_beq, iord, mem_rd, mem_we, alu_a_sel;
  logic [1:0] alu_b_sel, pc_src;
  logic       reg_we, wreg_dst_sel, wrbck_sel;
  logic [3:0] aluop;
  logic       instr_done, illegal_op;
  logic [3:0] state_debug;

  int checks   = 0;
  int failures = 0;
  int done_cnt;

  multicyc_mcu #(.MEMWAIT_EN(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .is_beq(is_beq), .iord(iord),
    .mem_rd(mem_rd), .mem_we(mem_we), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .pc_src(pc_src), .reg_we(reg_we),
    .wreg_dst_sel(wreg_dst_sel), .wrbck_sel(wrbck_sel), .aluop(aluop),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change here, well after the rising edge; outputs settle before the next check.
  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy);
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    applyStimulus(1'b1, 6'b000000, 1'b1);
    tick();
    tick();
    checkOutput("rst_state", state_debug, 0);
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_ir_we", ir_we, 0);
    checkOutput("rst_alu_b", alu_b_sel, 0);

    // lw, no wait: 0,1,2,3,4 then 0
    applyStimulus(1'b0, 6'b100011, 1'b1);
    checkOutput("lw_s0", state_debug, 0);
    checkOutput("lw_fetch_mem_rd", mem_rd, 1);
    checkOutput("lw_fetch_ir_we", ir_we, 1);
    checkOutput("lw_fetch_pc_we", pc_we, 1);
    checkOutput("lw_fetch_alu_b", alu_b_sel, 1);
    checkOutput("lw_fetch_iord", iord, 0);
    tick();
    checkOutput("lw_s1", state_debug, 1);
    checkOutput("lw_dec_alu_b", alu_b_sel, 3);
    checkOutput("lw_dec_reg_we", reg_we, 0);
    tick();
    checkOutput("lw_s2", state_debug, 2);
    checkOutput("lw_adr_alu_a", alu_a_sel, 1);
    checkOutput("lw_adr_alu_b", alu_b_sel, 2);
    tick();
    checkOutput("lw_s3", state_debug, 3);
    checkOutput("lw_rd_iord", iord, 1);
    checkOutput("lw_rd_mem_rd", mem_rd, 1);
    checkOutput("lw_rd_reg_we", reg_we, 0);
    tick();
    checkOutput("lw_s4", state_debug, 4);
    checkOutput("lw_wb_reg_we", reg_we, 1);
    checkOutput("lw_wb_wrbck", wrbck_sel, 1);
    checkOutput("lw_wb_dst", wreg_dst_sel, 0);
    checkOutput("lw_wb_done", instr_done, 1);
    tick();
    checkOutput("lw_end", state_debug, 0);

    // R-type: 0,1,6,7
    applyStimulus(1'b0, 6'b000000, 1'b1);
    done_cnt = 0;
    checkOutput("r_s0", state_debug, 0);
    done_cnt += int'(instr_done);
    tick();
    checkOutput("r_s1", state_debug, 1);
    done_cnt += int'(instr_done);
    tick();
    checkOutput("r_s6", state_debug, 6);
    checkOutput("r_exec_aluop", aluop, 2);
    checkOutput("r_exec_alu_b", alu_b_sel, 0);
    checkOutput("r_exec_alu_a", alu_a_sel, 1);
    done_cnt += int'(instr_done);
    tick();
    checkOutput("r_s7", state_debug, 7);
    checkOutput("r_wb_reg_we", reg_we, 1);
    checkOutput("r_wb_dst", wreg_dst_sel, 1);
    checkOutput("r_wb_wrbck", wrbck_sel, 0);
    done_cnt += int'(instr_done);
    tick();
    checkOutput("r_done_pulses", done_cnt[7:0], 1);
    checkOutput("r_end", state_debug, 0);

    // sw with 3 wait cycles in MEMWR: 0,1,2,5,5,5,5 (7 cycles)
    applyStimulus(1'b0, 6'b101011, 1'b1);
    checkOutput("sw_s0", state_debug, 0);
    tick();
    checkOutput("sw_s1", state_debug, 1);
    tick();
    checkOutput("sw_s2", state_debug, 2);
    tick();
    applyStimulus(1'b0, 6'b101011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sw_wait_state", state_debug, 5);
      checkOutput("sw_wait_mem_we", mem_we, 0);
      checkOutput("sw_wait_done", instr_done, 0);
      checkOutput("sw_wait_iord", iord, 1);
      tick();
    end
    applyStimulus(1'b0, 6'b101011, 1'b1);
    checkOutput("sw_rdy_state", state_debug, 5);
    checkOutput("sw_rdy_mem_we", mem_we, 1);
    checkOutput("sw_rdy_mem_rd", mem_rd, 0);
    checkOutput("sw_rdy_done", instr_done, 1);
    tick();
    checkOutput("sw_end", state_debug, 0);

    // beq: 0,1,8
    applyStimulus(1'b0, 6'b000100, 1'b1);
    tick();
    checkOutput("beq_s1", state_debug, 1);
    tick();
    checkOutput("beq_s8", state_debug, 8);
    checkOutput("beq_is_beq", is_beq, 1);
    checkOutput("beq_aluop", aluop, 1);
    checkOutput("beq_pc_src", pc_src, 1);
    checkOutput("beq_pc_we", pc_we, 0);
    checkOutput("beq_done", instr_done, 1);
    tick();
    checkOutput("beq_end", state_debug, 0);

    // j: 0,1,11
    applyStimulus(1'b0, 6'b000010, 1'b1);
    tick();
    checkOutput("j_s1", state_debug, 1);
    tick();
    checkOutput("j_s11", state_debug, 11);
    checkOutput("j_pc_we", pc_we, 1);
    checkOutput("j_pc_src", pc_src, 2);
    checkOutput("j_done", instr_done, 1);
    tick();
    checkOutput("j_end", state_debug, 0);

    // addi: 0,1,9,10
    applyStimulus(1'b0, 6'b001000, 1'b1);
    tick();
    tick();
    checkOutput("addi_s9", state_debug, 9);
    checkOutput("addi_alu_b", alu_b_sel, 2);
    checkOutput("addi_alu_a", alu_a_sel, 1);
    tick();
    checkOutput("addi_s10", state_debug, 10);
    checkOutput("addi_reg_we", reg_we, 1);
    checkOutput("addi_dst", wreg_dst_sel, 0);
    checkOutput("addi_done", instr_done, 1);
    tick();
    checkOutput("addi_end", state_debug, 0);

    // illegal opcode
    applyStimulus(1'b0, 6'b111111, 1'b1);
    checkOutput("ill_fetch_flag", illegal_op, 0);
    tick();
    checkOutput("ill_s1", state_debug, 1);
    checkOutput("ill_flag", illegal_op, 1);
    checkOutput("ill_reg_we", reg_we, 0);
    checkOutput("ill_mem_we", mem_we, 0);
    tick();
    checkOutput("ill_end", state_debug, 0);
    checkOutput("ill_flag_clr", illegal_op, 0);

    // Fetch stall: mem_ready low holds FETCH without loading IR or PC
    applyStimulus(1'b0, 6'b000010, 1'b0);
    checkOutput("fw_ir_we", ir_we, 0);
    checkOutput("fw_pc_we", pc_we, 0);
    checkOutput("fw_mem_rd", mem_rd, 1);
    tick();
    checkOutput("fw_hold", state_debug, 0);
    applyStimulus(1'b0, 6'b000010, 1'b1);
    tick();
    tick();
    checkOutput("fw_j_s11", state_debug, 11);
    tick();

    // Reset during MEMRD wait
    applyStimulus(1'b0, 6'b100011, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 6'b100011, 1'b0);
    checkOutput("rm_s3", state_debug, 3);
    checkOutput("rm_wait_mem_rd", mem_rd, 1);
    applyStimulus(1'b1, 6'b100011, 1'b0);
    checkOutput("rm_rst_mem_rd", mem_rd, 0);
    checkOutput("rm_rst_iord", iord, 0);
    checkOutput("rm_rst_dbg", state_debug, 0);
    tick();
    checkOutput("rm_held_state", state_debug, 0);
    checkOutput("rm_held_reg_we", reg_we, 0);
    checkOutput("rm_held_ir_we", ir_we, 0);
    applyStimulus(1'b0, 6'b100011, 1'b1);
    checkOutput("rm_rel_state", state_debug, 0);
    checkOutput("rm_rel_mem_rd", mem_rd, 1);
    checkOutput("rm_rel_ir_we", ir_we, 1);
    tick();
    checkOutput("rm_rel_s1", state_debug, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Read and write requests must never overlap, and writes happen only in MEMWR.
  always @(negedge clk) begin
    if (mem_rd && mem_we) begin
      checks++;
      failures++;
      $display("[TB] FAIL rd_we_overlap: got 1 expected 0");
    end
    if (mem_we && state_debug != 4'd5) begin
      checks++;
      failures++;
      $display("[TB] FAIL mem_we_state: got %0d expected 5", state_debug);
    end
  end

endmodule

// File: doc/multicyc_mcu.md
MULTICYC_MCU -- requirements
Module: multicyc_mcu

Interface
REQ-001 The block SHALL have parameter MEMWAIT_EN, default 1, meaning: 1 means memory states wait for mem_ready; 0 means the block treats mem_ready as constant 1.
REQ-002 The block SHALL have these ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- opcode  input  6  instruction-register bits [31:26].
- mem_ready  input  1  memory access completes this cycle.
- ir_we  output  1  load instruction register.
- pc_we  output  1  unconditional PC write.
- is_beq  output  1  PC write qualified by ALU eq.
- iord  output  1  memory address source: 0 is PC, 1 is ALU-out register.
- mem_rd  output  1  memory read request.
- mem_we  output  1  memory write request.
- alu_a_sel  output  1  ALU A source: 0 is PC, 1 is register A.
- alu_b_sel  output  2  ALU B source: 00 is register B, 01 is constant 4, 10 is sign_imm, 11 is sign_imm<<2.
- pc_src  output  2  next-PC source: 00 is ALU result, 01 is ALU-out register, 10 is jump target.
- reg_we  output  1  register file write enable.
- wreg_dst_sel  output  1  write-register source: 0 is Rt, 1 is Rd.
- wrbck_sel  output  1  write-back data source: 0 is ALU-out, 1 is memory data register.
- aluop  output  4  to alu_cu: 4'd0 is ADD, 4'd1 is SUB, 4'd2 is decode funct.
- instr_done  output  1  one-cycle pulse in the final state of each instruction.
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state_debug  output  4  current state encoding.

Function
REQ-003 The block SHALL be a Moore FSM, with every output decoded from the state register only, except the mem_ready gating defined below.
REQ-004 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-005 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-006 FETCH SHALL drive:
- iord=0, mem_rd=1, alu_a_sel=0, alu_b_sel=01, aluop=ADD, pc_src=00.
- ir_we=mem_ready and pc_we=mem_ready.
- On mem_ready go to DECODE; otherwise stay in FETCH.
REQ-007 DECODE SHALL drive alu_a_sel=0, alu_b_sel=11 and aluop=ADD, which precomputes the branch target. Next state by opcode:
- lw/sw go to MEMADR.
- R-type goes to EXEC.
- beq goes to BRANCH.
- addi goes to ADDIEXEC.
- j goes to JUMP.
- Any other opcode pulses illegal_op and goes to FETCH.
REQ-008 MEMADR SHALL drive alu_a_sel=1, alu_b_sel=10 and aluop=ADD. It goes to MEMRD for lw and to MEMWR for sw, using opcode held stable from the IR.
REQ-009 MEMRD SHALL drive iord=1 and mem_rd=1. It stays until mem_ready, then goes to MEMWB.
REQ-010 MEMWB SHALL drive reg_we=1, wreg_dst_sel=0, wrbck_sel=1 and instr_done=1, then go to FETCH.
REQ-011 MEMWR SHALL drive iord=1 and mem_we=mem_ready. It stays until mem_ready; on mem_ready it drives instr_done=1 and goes to FETCH.
REQ-012 EXEC SHALL drive alu_a_sel=1, alu_b_sel=00 and aluop=FUNCT, then go to ALUWB.
REQ-013 ALUWB SHALL drive reg_we=1, wreg_dst_sel=1, wrbck_sel=0 and instr_done=1, then go to FETCH.
REQ-014 BRANCH SHALL drive alu_a_sel=1, alu_b_sel=00, aluop=SUB, is_beq=1, pc_src=01 and instr_done=1, then go to FETCH.
REQ-015 ADDIEXEC SHALL drive alu_a_sel=1, alu_b_sel=10 and aluop=ADD, then go to ADDIWB.
REQ-016 ADDIWB SHALL drive reg_we=1, wreg_dst_sel=0, wrbck_sel=0 and instr_done=1, then go to FETCH.
REQ-017 JUMP SHALL drive pc_we=1, pc_src=10 and instr_done=1, then go to FETCH.
REQ-018 Any output not listed for a state SHALL be 0.
REQ-019 Unused encodings 12-15 SHALL drive all outputs to 0 and go to FETCH on the next edge.
REQ-020 Instruction latency with mem_ready held at 1 SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each wait cycle on mem_ready adds exactly one cycle.
REQ-021 mem_rd and mem_we SHALL never be 1 in the same cycle, and mem_we SHALL be 1 only in MEMWR.

Reset
REQ-022 While reset=1, the state register SHALL load FETCH on each rising edge.
REQ-023 While reset=1, the block SHALL force to 0: ir_we, pc_we, is_beq, mem_rd, mem_we, reg_we, instr_done and illegal_op.
REQ-024 While reset=1, every other output SHALL be 0 and state_debug SHALL read 0.
REQ-025 Reset asserted in any state, including mid-wait in MEMRD or MEMWR, SHALL abort the instruction with no register or memory write in that cycle.
REQ-026 The first cycle after reset deasserts SHALL be FETCH.

Verification
REQ-027 Scenario, lw: opcode=100011, mem_ready=1 -> state_debug sequence 0,1,2,3,4; reg_we=1 and wrbck_sel=1 only in the cycle with state 4; then state 0.
REQ-028 Scenario, R-type: opcode=000000 -> states 0,1,6,7; aluop=2 in state 6; reg_we=1 and wreg_dst_sel=1 in state 7; instr_done pulses once.
REQ-029 Scenario, memory wait: sw with mem_ready=0 for 3 cycles in MEMWR -> state stays 5 for 4 cycles; mem_we=0 during the wait and 1 only in the mem_ready cycle; 7 cycles total.
REQ-030 Scenario, beq and j: beq -> states 0,1,8 with is_beq=1, aluop=1 and pc_src=01 in state 8; j -> states 0,1,11 with pc_we=1 and pc_src=10 in state 11.
REQ-031 Scenario, illegal opcode: opcode=111111 -> illegal_op=1 for one cycle in state 1, then state 0, with no reg_we or mem_we ever asserted.
REQ-032 Scenario, reset mid-operation: reset=1 during state 3 with mem_ready=0 -> next state 0, all enables 0 while reset is held; after release, a FETCH proceeds normally.
